// File: rtl/hdmi_cfg_sequencer.sv
// hdmi_cfg_sequencer
//   Walks a {reg, value} table held in an external registered ROM and issues
//   each entry as a single I2C write to a byte-level I2C master. NACKed writes
//   are retried after a gap. The whole table is re-run on an HDMI hot-plug
//   rise or on a start request. Lives in the 27 MHz configuration domain.
// Ports
//   clk, rst           configuration clock, async active-high reset
//   start              single-cycle re-run request (honoured only when idle)
//   hpd                raw hot-plug detect pin (synchronized internally)
//   rom_addr/rom_data  table index out, {reg,value} back one cycle later
//   cmd_*              write command to the I2C master (valid/ready)
//   rsp_valid/rsp_nack completion of the accepted command
//   busy/done/error    sequence status, err_index = failing table entry
module hdmi_cfg_sequencer #(
   parameter int         NUM_REGS     = 16,
   parameter logic [6:0] DEV_ADDR     = 7'h39,
   parameter int         POWERUP_WAIT = 27000,
   parameter int         RETRY_GAP    = 270,
   parameter int         DELAY_CYCLES = 2700,
   parameter int         MAX_RETRY    = 3,
   localparam int        IW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          hpd,
   output logic [IW-1:0] rom_addr,
   input  logic [15:0]   rom_data,
   output logic          cmd_valid,
   input  logic          cmd_ready,
   output logic [6:0]    cmd_dev,
   output logic [7:0]    cmd_reg,
   output logic [7:0]    cmd_data,
   input  logic          rsp_valid,
   input  logic          rsp_nack,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [IW-1:0] err_index
);

   localparam int WMAX0 = (POWERUP_WAIT > RETRY_GAP) ? POWERUP_WAIT : RETRY_GAP;
   localparam int WMAX  = (WMAX0 > DELAY_CYCLES) ? WMAX0 : DELAY_CYCLES;
   localparam int CW    = (WMAX > 0) ? $clog2(WMAX + 1) : 1;
   localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [3:0] S_WAIT_PWR = 4'd0;
   localparam logic [3:0] S_FETCH    = 4'd1;
   localparam logic [3:0] S_LATCH    = 4'd2;
   localparam logic [3:0] S_ISSUE    = 4'd3;
   localparam logic [3:0] S_WAIT_RSP = 4'd4;
   localparam logic [3:0] S_GAP      = 4'd5;
   localparam logic [3:0] S_DELAY    = 4'd6;
   localparam logic [3:0] S_DONE     = 4'd7;
   localparam logic [3:0] S_ERROR    = 4'd8;

   localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

   logic [3:0]    state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [RW-1:0] rc;
   logic          hpd_s1, hpd_s2, hpd_s3, hpd_edge, hpd_pend;
   logic          pend;

   // Two sync flops, then a registered rising-edge detect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hpd_s1   <= 1'b0;
         hpd_s2   <= 1'b0;
         hpd_s3   <= 1'b0;
         hpd_edge <= 1'b0;
      end else begin
         hpd_s1   <= hpd;
         hpd_s2   <= hpd_s1;
         hpd_s3   <= hpd_s2;
         hpd_edge <= hpd_s2 & ~hpd_s3;
      end
   end

   // A rise arriving this cycle counts as pending so it is not lost when the
   // take point and the edge coincide.
   assign pend = hpd_pend | hpd_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_WAIT_PWR;
         cnt       <= CW'(POWERUP_WAIT);
         idx       <= '0;
         rc        <= '0;
         cmd_valid <= 1'b0;
         cmd_reg   <= 8'h00;
         cmd_data  <= 8'h00;
         err_index <= '0;
         hpd_pend  <= 1'b0;
      end else begin
         if (busy && hpd_edge) hpd_pend <= 1'b1;
         case (state)
            S_WAIT_PWR: begin
               if (pend) begin
                  cnt      <= CW'(POWERUP_WAIT);
                  hpd_pend <= 1'b0;
               end else if (cnt == '0) begin
                  idx   <= '0;
                  state <= S_FETCH;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_FETCH: begin
               if (pend) begin
                  cnt      <= CW'(POWERUP_WAIT);
                  hpd_pend <= 1'b0;
                  state    <= S_WAIT_PWR;
               end else begin
                  state <= S_LATCH;
               end
            end
            S_LATCH: begin
               if (rom_data == 16'hFFFF) begin
                  cnt   <= CW'(DELAY_CYCLES);
                  state <= S_DELAY;
               end else begin
                  cmd_reg   <= rom_data[15:8];
                  cmd_data  <= rom_data[7:0];
                  rc        <= '0;
                  cmd_valid <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= S_WAIT_RSP;
               end
            end
            S_WAIT_RSP: begin
               // The outstanding command always completes before a restart.
               if (rsp_valid) begin
                  if (pend) begin
                     cnt      <= CW'(POWERUP_WAIT);
                     hpd_pend <= 1'b0;
                     state    <= S_WAIT_PWR;
                  end else if (!rsp_nack) begin
                     if (idx == LAST) state <= S_DONE;
                     else begin
                        idx   <= idx + IW'(1);
                        state <= S_FETCH;
                     end
                  end else if (rc < RW'(MAX_RETRY)) begin
                     rc    <= rc + RW'(1);
                     cnt   <= CW'(RETRY_GAP);
                     state <= S_GAP;
                  end else begin
                     err_index <= idx;
                     state     <= S_ERROR;
                  end
               end
            end
            S_GAP: begin
               if (pend) begin
                  cnt      <= CW'(POWERUP_WAIT);
                  hpd_pend <= 1'b0;
                  state    <= S_WAIT_PWR;
               end else if (cnt == '0) begin
                  cmd_valid <= 1'b1;
                  state     <= S_ISSUE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_DELAY: begin
               if (pend) begin
                  cnt      <= CW'(POWERUP_WAIT);
                  hpd_pend <= 1'b0;
                  state    <= S_WAIT_PWR;
               end else if (cnt == '0) begin
                  if (idx == LAST) state <= S_DONE;
                  else begin
                     idx   <= idx + IW'(1);
                     state <= S_FETCH;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_DONE, S_ERROR: begin
               // Hot-plug restarts with the power-up wait; start skips it.
               if (hpd_edge) begin
                  cnt   <= CW'(POWERUP_WAIT);
                  state <= S_WAIT_PWR;
               end else if (start) begin
                  idx   <= '0;
                  state <= S_FETCH;
               end
            end
            default: begin
               cmd_valid <= 1'b0;
               cnt       <= CW'(POWERUP_WAIT);
               state     <= S_WAIT_PWR;
            end
         endcase
      end
   end

   assign rom_addr = idx;
   assign cmd_dev  = DEV_ADDR;
   assign done     = (state == S_DONE);
   assign error    = (state == S_ERROR);
   assign busy     = ~(done | error);

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Directed bench for hdmi_cfg_sequencer: registered ROM model, hand-driven
// I2C master handshake, hand-computed latencies and payloads.
module tb_hdmi_cfg_sequencer;

   localparam int IW = 2;

   logic          clk, rst, start, hpd;
   logic [IW-1:0] rom_addr;
   logic [15:0]   rom_data;
   logic          cmd_valid, cmd_ready;
   logic [6:0]    cmd_dev;
   logic [7:0]    cmd_reg, cmd_data;
   logic          rsp_valid, rsp_nack;
   logic          busy, done, error;
   logic [IW-1:0] err_index;

   hdmi_cfg_sequencer #(
      .NUM_REGS(4), .DEV_ADDR(7'h39), .POWERUP_WAIT(10), .RETRY_GAP(4),
      .DELAY_CYCLES(5), .MAX_RETRY(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .hpd(hpd),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev),
      .cmd_reg(cmd_reg), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
      .busy(busy), .done(done), .error(error), .err_index(err_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] rom [4];
   always @(posedge clk) rom_data <= rom[rom_addr];

   int ncmd = 0;
   always @(posedge clk) if (cmd_valid && cmd_ready) ncmd <= ncmd + 1;

   int vec  = 0;
   int miss = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Ticks until cmd_valid is seen (bounded).
   task automatic wait_cmd(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (cmd_valid !== 1'b1 && n < 200);
   endtask

   task automatic accept();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      chk("cmd_valid_drop", cmd_valid, 1'b0);
   endtask

   task automatic respond(input bit nack);
      rsp_valid = 1'b1;
      rsp_nack  = nack;
      tick();
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
   endtask

   task automatic xfer(input bit nack);
      accept();
      tick();
      tick();
      respond(nack);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // From entry 0's command being valid, run the remaining all-ACK pass.
   task automatic run_tail();
      int n;
      xfer(1'b0);
      wait_cmd(n);
      chk("delay_entry_lat", n, 10);
      chk("e2_reg", cmd_reg, 8'h98);
      chk("e2_data", cmd_data, 8'h03);
      xfer(1'b0);
      wait_cmd(n);
      chk("ack_lat", n, 2);
      chk("e3_reg", cmd_reg, 8'hAF);
      chk("e3_data", cmd_data, 8'h16);
      xfer(1'b0);
      chk("done_set", done, 1'b1);
      chk("busy_clr", busy, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, c0;
      bit bad;
      rom[0] = 16'h4110; rom[1] = 16'hFFFF; rom[2] = 16'h9803; rom[3] = 16'hAF16;
      rst = 1'b1; start = 1'b0; hpd = 1'b0;
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
      tick(); tick();

      // reset state
      chk("rst_cmd_valid", cmd_valid, 1'b0);
      chk("rst_busy", busy, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_err_index", err_index, 2'd0);
      chk("rst_rom_addr", rom_addr, 2'd0);
      chk("rst_cmd_reg", cmd_reg, 8'h00);
      chk("rst_cmd_data", cmd_data, 8'h00);
      chk("cmd_dev", cmd_dev, 7'h39);

      // all-ACK pass after reset
      rst = 1'b0;
      wait_cmd(n);
      chk("pwr_lat", n, 13);
      chk("e0_reg", cmd_reg, 8'h41);
      chk("e0_data", cmd_data, 8'h10);
      c0 = ncmd;
      run_tail();
      chk("pass1_ncmd", ncmd - c0, 3);
      repeat (10) tick();
      chk("idle_no_cmd", cmd_valid, 1'b0);
      chk("done_sticky", done, 1'b1);

      // entry 2 NACKs twice then ACKs
      pulse_start();
      chk("start_clr_done", done, 1'b0);
      chk("start_busy", busy, 1'b1);
      wait_cmd(n);
      chk("start_lat", n, 2);
      c0 = ncmd;
      xfer(1'b0);
      wait_cmd(n);
      chk("p2_delay_lat", n, 10);
      xfer(1'b1);
      wait_cmd(n);
      chk("retry1_lat", n, 5);
      chk("retry1_reg", cmd_reg, 8'h98);
      chk("retry1_data", cmd_data, 8'h03);
      xfer(1'b1);
      wait_cmd(n);
      chk("retry2_lat", n, 5);
      chk("retry2_reg", cmd_reg, 8'h98);
      xfer(1'b0);
      wait_cmd(n);
      chk("p2_ack_lat", n, 2);
      chk("p2_e3_reg", cmd_reg, 8'hAF);
      xfer(1'b0);
      chk("p2_done", done, 1'b1);
      chk("p2_ncmd", ncmd - c0, 5);

      // entry 2 NACKs three times -> error
      pulse_start();
      wait_cmd(n);
      xfer(1'b0);
      wait_cmd(n);
      xfer(1'b1);
      wait_cmd(n);
      xfer(1'b1);
      wait_cmd(n);
      chk("p3_retry2_lat", n, 5);
      xfer(1'b1);
      chk("err_set", error, 1'b1);
      chk("err_index", err_index, 2'd2);
      chk("err_done", done, 1'b0);
      chk("err_busy", busy, 1'b0);
      bad = 1'b0;
      repeat (20) begin
         tick();
         if (cmd_valid !== 1'b0 || error !== 1'b1) bad = 1'b1;
      end
      chk("err_quiet", bad, 1'b0);
      pulse_start();
      chk("start_clr_err", error, 1'b0);
      wait_cmd(n);
      chk("err_restart_lat", n, 2);
      chk("err_restart_reg", cmd_reg, 8'h41);

      // back-pressure: cmd_ready low for 20 cycles
      bad = 1'b0;
      repeat (20) begin
         tick();
         if (cmd_valid !== 1'b1 || cmd_reg !== 8'h41 || cmd_data !== 8'h10) bad = 1'b1;
      end
      chk("hold_stable", bad, 1'b0);
      c0 = ncmd;
      run_tail();
      chk("hold_ncmd", ncmd - c0, 3);

      // hpd rise while waiting for entry 0's response
      pulse_start();
      wait_cmd(n);
      accept();
      hpd = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         start = (i == 4);
         tick();
         if (cmd_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      end
      start = 1'b0;
      chk("hpd_wait_rsp", bad, 1'b0);
      respond(1'b0);
      wait_cmd(n);
      chk("hpd_restart_lat", n, 13);
      chk("hpd_restart_reg", cmd_reg, 8'h41);
      chk("hpd_restart_done", done, 1'b0);
      run_tail();
      hpd = 1'b0;
      repeat (5) tick();

      // reset during ISSUE
      pulse_start();
      wait_cmd(n);
      chk("pre_rst_valid", cmd_valid, 1'b1);
      rst = 1'b1;
      #1;
      chk("async_rst_valid", cmd_valid, 1'b0);
      chk("async_rst_busy", busy, 1'b1);
      chk("async_rst_done", done, 1'b0);
      chk("async_rst_reg", cmd_reg, 8'h00);
      chk("async_rst_addr", rom_addr, 2'd0);
      tick();
      rst = 1'b0;
      wait_cmd(n);
      chk("rst2_pwr_lat", n, 13);
      run_tail();

      // hpd rise while done: 3-cycle sync, then full power-up wait
      hpd = 1'b1;
      wait_cmd(n);
      chk("hpd_done_lat", n, 17);
      chk("hpd_done_reg", cmd_reg, 8'h41);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/hdmi_cfg_sequencer.md
# hdmi_cfg_sequencer

Sequences the HDMI transmitter register setup. It walks a table of {register, value} pairs held in an external synchronous ROM and issues each pair as one I2C write command to a byte-level I2C master. It retries NACKed writes, re-runs the whole table on HDMI hot-plug or on request, and reports done/error status. It sits between the board-level reset/clock logic and the HDMI I2C master, in the 27 MHz configuration clock domain.

## Interface
- NUM_REGS, 16: number of table entries, at least 1; index width IW = max(1, $clog2(NUM_REGS)).
- DEV_ADDR, 7'h39: 7-bit I2C device address placed on every command.
- POWERUP_WAIT, 27000: idle cycles before the first command after reset or hot-plug (1 ms at 27 MHz).
- RETRY_GAP, 270: idle cycles between a NACK and the retry.
- DELAY_CYCLES, 2700: stall length for a delay-marker entry.
- MAX_RETRY, 3: retries per entry after the first attempt.
- clk  in  1  configuration clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to re-run the table.
- hpd  in  1  hot-plug detect, asynchronous; a 2-flop synchronizer is internal.
- rom_addr  out  IW  table index; registered ROM, data valid one cycle later.
- rom_data  in  16  {reg[15:8], value[7:0]}; 16'hFFFF is a delay marker.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  command accepted by the I2C master.
- cmd_dev  out  7  device address.
- cmd_reg  out  8  register address.
- cmd_data  out  8  write value.
- rsp_valid  in  1  single-cycle completion of the accepted command.
- rsp_nack  in  1  qualifies rsp_valid; 1 means NACK.
- busy  out  1  sequence in progress, including waits.
- done  out  1  last pass completed without error.
- error  out  1  last pass aborted after retries were exhausted.
- err_index  out  IW  index of the failing entry.

## Operation
- States: WAIT_PWR, FETCH, LATCH, ISSUE, WAIT_RSP, GAP, DELAY, DONE, ERROR.
- One down-counter serves WAIT_PWR, GAP and DELAY. Its width is sized for the largest of the three wait parameters.
- WAIT_PWR: load POWERUP_WAIT, count to 0, then set idx=0 and go to FETCH.
- FETCH: drive rom_addr=idx, then go to LATCH.
- LATCH:
  - rom_data==16'hFFFF: go to DELAY with the counter loaded to DELAY_CYCLES. No command is issued.
  - Otherwise: capture cmd_reg and cmd_data, set retry count rc=0, go to ISSUE.
- ISSUE: assert cmd_valid. On cmd_valid&cmd_ready, drop cmd_valid the next cycle and go to WAIT_RSP.
- WAIT_RSP: wait for rsp_valid.
  - ACK: if idx==NUM_REGS-1 go to DONE; otherwise idx+1, go to FETCH.
  - NACK with rc<MAX_RETRY: rc+1, go to GAP (load RETRY_GAP). At count 0 return to ISSUE with the same payload.
  - NACK with rc==MAX_RETRY: set err_index=idx and go to ERROR.
- DELAY: count to 0, then advance exactly as on an ACK.
- DONE asserts done=1. ERROR asserts error=1. Both are sticky; busy=0 in both.
- Re-run triggers:
  - start in DONE or ERROR: clear done/error, set idx=0, go to FETCH (no power-up wait).
  - hpd rising edge (after sync) in DONE or ERROR: clear done/error, go to WAIT_PWR.
- While busy, start is ignored.
- While busy, an hpd rise sets hpd_pend. The pending restart is taken only at one of these points:
  - in FETCH, GAP or DELAY;
  - in WAIT_PWR, where it reloads the counter;
  - after rsp_valid in WAIT_RSP.
  - At any of these points it clears hpd_pend and goes to WAIT_PWR. An outstanding I2C command is never abandoned.
- rsp_valid outside WAIT_RSP is ignored. cmd_ready outside ISSUE is ignored.
- cmd_dev is always DEV_ADDR.

## Timing
- Reset values (asynchronous):
  - state=WAIT_PWR with the counter loaded to POWERUP_WAIT;
  - cmd_valid=0, cmd_reg=0, cmd_data=0, rom_addr=0;
  - busy=1, done=0, error=0, err_index=0, hpd_pend=0, hpd sync flops=0.
- Reset asserted mid-transaction drops cmd_valid immediately. There is no recovery handshake with the I2C master; it shares rst.
- Latency:
  - reset release to first cmd_valid: POWERUP_WAIT+3 cycles (count, FETCH, LATCH, ISSUE);
  - ACK to next cmd_valid: 3 cycles;
  - NACK to retry cmd_valid: RETRY_GAP+2 cycles.
- Handshake: cmd_valid stays high with a stable payload until accepted. It never depends on cmd_ready combinationally.
- hpd edge reaches the FSM 3 cycles after it appears at the pin (2 sync flops plus edge register).
- busy falls in the same cycle that done or error rises.

## Test plan
Bench parameters: NUM_REGS=4, POWERUP_WAIT=10, RETRY_GAP=4, DELAY_CYCLES=5, MAX_RETRY=2. ROM contents: {16'h4110, 16'hFFFF, 16'h9803, 16'hAF16}.
- All ACK after reset -> first cmd_valid at cycle 13 with cmd_reg=8'h41, cmd_data=8'h10. Exactly 3 commands are issued (the delay entry issues none, and its stall is at least 5 cycles). done=1 and busy=0 after the ACK of entry 3.
- Entry 2 NACKs twice, then ACKs -> 3 issues of reg 8'h98, each retry spaced RETRY_GAP+2 cycles from its NACK. done=1.
- Entry 2 NACKs 3 times -> error=1, err_index=2, done=0, no further cmd_valid. A start pulse then re-runs from entry 0 with no power-up wait.
- cmd_ready held low 20 cycles -> cmd_valid and the payload stay stable for all 20 cycles; there is one transfer per acceptance.
- hpd rises while WAIT_RSP is pending on entry 0 -> no new command until rsp_valid. Then WAIT_PWR runs 10 cycles and the sequence restarts at entry 0. start pulses while busy have no effect.
- rst asserted during ISSUE -> cmd_valid=0 asynchronously and all outputs return to their reset values. The power-up wait restarts from the full count.
